rs232_tx_arbiter: RTL and testbench
===================================

// Module: rs232_tx_arbiter
// PURPOSE
//  Round-robin, packet-granular arbiter sharing one rs232 transmit stream
//  (rs232_send3 or a fifo in front of it) among COUNT byte-stream requesters.
//  A grant is held from a packet's first byte to its last byte, so packets
//  never interleave on the serial line. A byte-count limit bounds each grant
//  and prevents starvation. Sits between the application sources and the tx fifo.
// PARAMETERS
//  COUNT   4    number of requesters, 2..8
//  MAXLEN  64   max bytes per grant; forced release after MAXLEN bytes, 1..256
// PORTS
//  clock    in   1        system clock (133 MHz OSCH)
//  resetn   in   1        asynchronous active-low reset
//  idata    in   8*COUNT  requester bytes; requester i on idata[8*i+7:8*i]
//  ivalid   in   COUNT    per-requester byte valid
//  ilast    in   COUNT    per-requester last-byte-of-packet flag, qualified by ivalid
//  iready   out  COUNT    per-requester accept
//  odata    out  8        shared output byte
//  ovalid   out  1        output valid
//  olast    out  1        last byte of the current grant
//  oready   in   1        downstream accept (fifo iready)
//  grant    out  COUNT    one-hot current owner; all zero when idle
//  busy     out  1        high in any state other than IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, grant=0, iready=0, ovalid=0, olast=0, odata=0, busy=0,
//    byte counter=0, rr pointer=COUNT-1 (requester 0 has first priority).
//  - Transfer: a cycle with ovalid&&oready. Requester handshake is
//    ivalid[i]&&iready[i]. Data is never dropped or duplicated.
//  - IDLE: when any ivalid is set, pick the first i with ivalid[i] set,
//    searching cyclically from pointer+1. Register grant=onehot(i), pointer=i,
//    counter=0, then go to PASS (or HDR with the option). No output in this cycle:
//    one-cycle arbitration bubble per packet.
//  - PASS: combinational pass-through from the owner g:
//    odata=idata[g], ovalid=ivalid[g], iready[g]=oready, other iready=0.
//    olast = ilast[g] | (counter==MAXLEN-1).
//    On each transfer, counter increments (9-bit, no wrap within a grant).
//    On a transfer with olast=1: grant=0, go to IDLE.
//    If the owner deasserts ivalid mid-packet, the grant is held (no timeout).
//  - MAXLEN release: the owner's next byte starts a new arbitration round.
//    ilast is not implied for that requester's later bytes.
//  - Simultaneous requests in IDLE: round-robin order only. A request arriving
//    in the same cycle as a release is seen in the following IDLE cycle.
//  - ivalid/idata of non-owners are ignored; their iready stays 0.
//  - Async reset mid-packet: immediate return to reset values. A partial packet
//    already sent downstream is not retracted.
// CONFIGURATION
//  RS232_TX_ARB_TAG_EN defined: IDLE -> HDR -> PASS. HDR drives
//    ovalid=1, odata={5'b10100,id[2:0]}, olast=0, all iready=0. Hold until
//    oready, then go to PASS. The header byte does not count toward MAXLEN.
//  RS232_TX_ARB_TAG_EN undefined: no HDR state. Output holds payload bytes only.
// TESTING
//  1 Reset: hold resetn=0 with all ivalid=1 -> iready=0, ovalid=0, grant=0, busy=0.
//  2 Round-robin: all 4 send 1-byte packets (ilast=1) continuously, oready=1
//    -> grant order 0,1,2,3,0. One transfer every 2 cycles.
//  3 Backpressure: req1 sends 5-byte packet A1..A5; oready toggles 1,0 each cycle
//    -> odata=A1..A5 in order, no loss, olast only with A5, then grant=0.
//  4 MAXLEN=4: req2 streams 10 bytes without ilast while req3 waits
//    -> 4 bytes from 2 with olast on byte 4, then req3's packet, then req2 resumes.
//  5 No interleave: req0 mid-packet drops ivalid for 5 cycles while req1 is valid
//    -> grant stays 0001. req1 gets its first byte only after req0's ilast.
//  6 Tag option on: req2 sends packet 0x55,0x66(last) -> odata=0xA2,0x55,0x66.
//    Reset asserted during 0x55 -> all outputs return to reset values at once.

Source files
------------

// File: rtl/rs232_tx_arbiter_if.sv
// Byte-stream bus between the requesters, the tx arbiter and the tx fifo.
// Requester i owns byte lane idata[8*i+7:8*i].
interface rs232_tx_arbiter_if #(
    parameter int COUNT = 4
);
    logic [8*COUNT-1:0] idata;
    logic [COUNT-1:0]   ivalid;
    logic [COUNT-1:0]   ilast;
    logic [COUNT-1:0]   iready;
    logic [7:0]         odata;
    logic               ovalid;
    logic               olast;
    logic               oready;
    logic [COUNT-1:0]   grant;
    logic               busy;

    modport master (
        output idata, ivalid, ilast, oready,
        input  iready, odata, ovalid, olast, grant, busy
    );

    modport slave (
        input  idata, ivalid, ilast, oready,
        output iready, odata, ovalid, olast, grant, busy
    );
endinterface

// File: rtl/rs232_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the rs232 tx stream.
// Optional per-packet header byte: define RS232_TX_ARB_TAG_EN.
module rs232_tx_arbiter #(
    parameter int COUNT  = 4,
    parameter int MAXLEN = 64
) (
    input logic               clock,
    input logic               resetn,
    rs232_tx_arbiter_if.slave bus
);
    localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        HDR
    } state_t;

    state_t           state_q, state_d;
    logic [COUNT-1:0] grant_q, grant_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [8:0]       cnt_q, cnt_d;

    logic [IW-1:0]    pick;
    logic             found;
    logic             xfer;
    logic             last;
`ifdef RS232_TX_ARB_TAG_EN
    logic [2:0]       id3;
    assign id3 = 3'(ptr_q);
`endif

    // Cyclic search starting just after the previous owner.
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        pick  = ptr_q;
        for (int k = 1; k <= COUNT; k++) begin
            j = (int'(ptr_q) + k) % COUNT;
            if (!found && bus.ivalid[j]) begin
                found = 1'b1;
                pick  = IW'(j);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        xfer       = 1'b0;
        last       = 1'b0;
        bus.iready = '0;
        bus.odata  = '0;
        bus.ovalid = 1'b0;
        bus.olast  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = COUNT'(1) << pick;
                    ptr_d   = pick;
                    cnt_d   = '0;
`ifdef RS232_TX_ARB_TAG_EN
                    state_d = HDR;
`else
                    state_d = PASS;
`endif
                end
            end
            PASS: begin
                xfer = bus.ivalid[ptr_q] && bus.oready;
                last = bus.ilast[ptr_q] || (cnt_q == 9'(MAXLEN - 1));
                bus.odata          = bus.idata[8*ptr_q +: 8];
                bus.ovalid         = bus.ivalid[ptr_q];
                bus.olast          = last;
                bus.iready[ptr_q]  = bus.oready;
                if (xfer) begin
                    cnt_d = cnt_q + 9'd1;
                    if (last) begin
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end
            end
`ifdef RS232_TX_ARB_TAG_EN
            HDR: begin
                bus.ovalid = 1'b1;
                bus.odata  = {5'b10100, id3};
                if (bus.oready) state_d = PASS;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= IW'(COUNT - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = (state_q != IDLE);
endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Directed bench for rs232_tx_arbiter: one instance with MAXLEN=64 and one
// with MAXLEN=4 share the same stimulus; a selector picks whose outputs count.
module tb_rs232_tx_arbiter;
    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    logic [31:0] idata;
    logic [3:0]  ivalid;
    logic [3:0]  ilast;
    logic        oready;
    logic        use4;

    rs232_tx_arbiter_if #(.COUNT(4)) bus64 ();
    rs232_tx_arbiter_if #(.COUNT(4)) bus4 ();

    assign bus64.idata  = idata;
    assign bus64.ivalid = ivalid;
    assign bus64.ilast  = ilast;
    assign bus64.oready = oready;
    assign bus4.idata   = idata;
    assign bus4.ivalid  = ivalid;
    assign bus4.ilast   = ilast;
    assign bus4.oready  = oready;

    rs232_tx_arbiter #(.COUNT(4), .MAXLEN(64)) u_dut64 (
        .clock(clock), .resetn(resetn), .bus(bus64));
    rs232_tx_arbiter #(.COUNT(4), .MAXLEN(4)) u_dut4 (
        .clock(clock), .resetn(resetn), .bus(bus4));

    logic [3:0] s_iready, s_grant;
    logic [7:0] s_odata;
    logic       s_ovalid, s_olast, s_busy;
    always_comb begin
        s_iready = use4 ? bus4.iready : bus64.iready;
        s_grant  = use4 ? bus4.grant  : bus64.grant;
        s_odata  = use4 ? bus4.odata  : bus64.odata;
        s_ovalid = use4 ? bus4.ovalid : bus64.ovalid;
        s_olast  = use4 ? bus4.olast  : bus64.olast;
        s_busy   = use4 ? bus4.busy   : bus64.busy;
    end

`ifdef RS232_TX_ARB_TAG_EN
    localparam int GAP = 3;
`else
    localparam int GAP = 2;
`endif

    int errs = 0;
    int nchk = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // requester model: per-lane byte list, position and optional pause
    logic [7:0] pd[4][16];
    bit         pl[4][16];
    int         plen[4], ppos[4];
    int         gap_at[4], gap_len[4], gap_cnt[4];
    bit         pend[4];
    bit         tog;
    int         cyc;

    logic [7:0] obs_d[32];
    logic       obs_l[32];
    logic [3:0] obs_g[32];
    int         obs_c[32];
    int         nobs;

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            plen[i] = 0; ppos[i] = 0; pend[i] = 0;
            gap_at[i] = -1; gap_len[i] = 0; gap_cnt[i] = 0;
        end
        nobs = 0; tog = 0; oready = 1'b1;
        idata = '0; ivalid = '0; ilast = '0;
    endtask

    task automatic drive();
        bit v;
        for (int i = 0; i < 4; i++) begin
            if (pend[i]) ppos[i]++;
            pend[i] = 0;
            v = ppos[i] < plen[i];
            if (v && ppos[i] == gap_at[i] && gap_cnt[i] < gap_len[i]) begin
                v = 0;
                gap_cnt[i]++;
            end
            ivalid[i] = v;
            if (v) begin
                idata[8*i +: 8] = pd[i][ppos[i]];
                ilast[i]        = pl[i][ppos[i]];
            end else begin
                idata[8*i +: 8] = 8'h00;
                ilast[i]        = 1'b0;
            end
        end
        oready = tog ? ~oready : 1'b1;
    endtask

    // Inputs change just after posedge; outputs are sampled at negedge.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        drive();
        @(negedge clock);
        for (int i = 0; i < 4; i++) pend[i] = ivalid[i] && s_iready[i];
        if (s_ovalid && oready && (|s_iready) && nobs < 32) begin
            obs_d[nobs] = s_odata;
            obs_l[nobs] = s_olast;
            obs_g[nobs] = s_grant;
            obs_c[nobs] = cyc;
            nobs++;
        end
    endtask

    task automatic restart();
        resetn = 1'b0;
        model_clear();
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic run_until(input int n, input int budget);
        for (int t = 0; t < budget && nobs < n; t++) step();
    endtask

    logic [7:0] e2d[5]  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20};
    logic [3:0] e2g[5]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [7:0] e4d[12] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h40, 8'h41,
                            8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    logic       e4l[12] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0};
    logic [3:0] e4g[12] = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h8, 4'h8,
                            4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4};
    logic [7:0] e5d[5]  = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60};
    logic [3:0] e5g[5]  = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2};

    initial begin
        cyc    = 0;
        use4   = 1'b0;
        resetn = 1'b0;
        model_clear();

        // reset held with every requester valid
        for (int i = 0; i < 4; i++) begin
            plen[i] = 1; pd[i][0] = 8'hE0 + 8'(i); pl[i][0] = 1;
        end
        step(); step(); step();
        check_eq("rst_iready", 32'(s_iready), 32'h0);
        check_eq("rst_ovalid", 32'(s_ovalid), 32'h0);
        check_eq("rst_grant", 32'(s_grant), 32'h0);
        check_eq("rst_busy", 32'(s_busy), 32'h0);
        check_eq("rst_odata", 32'(s_odata), 32'h0);

        // round robin over single-byte packets
        restart();
        for (int i = 0; i < 4; i++) begin
            plen[i] = 2;
            pd[i][0] = 8'h10 + 8'(i); pl[i][0] = 1;
            pd[i][1] = 8'h20 + 8'(i); pl[i][1] = 1;
        end
        run_until(5, 60);
        check_eq("rr_count", nobs, 5);
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("rr_data%0d", k), 32'(obs_d[k]), 32'(e2d[k]));
            check_eq($sformatf("rr_grant%0d", k), 32'(obs_g[k]), 32'(e2g[k]));
        end
        for (int k = 0; k < 4; k++)
            check_eq($sformatf("rr_gap%0d", k), obs_c[k+1] - obs_c[k], GAP);

        // backpressure on a 5-byte packet
        restart();
        plen[1] = 5;
        for (int k = 0; k < 5; k++) begin
            pd[1][k] = 8'hA1 + 8'(k); pl[1][k] = (k == 4);
        end
        tog = 1; oready = 1'b0;
        run_until(5, 60);
        for (int k = 0; k < 3; k++) step();
        check_eq("bp_count", nobs, 5);
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("bp_data%0d", k), 32'(obs_d[k]), 32'hA1 + k);
            check_eq($sformatf("bp_last%0d", k), 32'(obs_l[k]), 32'(k == 4));
        end
        check_eq("bp_grant_end", 32'(s_grant), 32'h0);
        check_eq("bp_busy_end", 32'(s_busy), 32'h0);

        // MAXLEN=4 release and resume
        use4 = 1'b1;
        restart();
        plen[2] = 10;
        for (int k = 0; k < 10; k++) begin
            pd[2][k] = 8'h30 + 8'(k); pl[2][k] = 0;
        end
        plen[3] = 2;
        pd[3][0] = 8'h40; pl[3][0] = 0;
        pd[3][1] = 8'h41; pl[3][1] = 1;
        run_until(12, 80);
        for (int k = 0; k < 6; k++) step();
        check_eq("ml_count", nobs, 12);
        for (int k = 0; k < 12; k++) begin
            check_eq($sformatf("ml_data%0d", k), 32'(obs_d[k]), 32'(e4d[k]));
            check_eq($sformatf("ml_last%0d", k), 32'(obs_l[k]), 32'(e4l[k]));
            check_eq($sformatf("ml_grant%0d", k), 32'(obs_g[k]), 32'(e4g[k]));
        end
        check_eq("ml_hold_grant", 32'(s_grant), 32'h4);
        check_eq("ml_hold_busy", 32'(s_busy), 32'h1);

        // owner pauses mid-packet while another requester waits
        use4 = 1'b0;
        restart();
        plen[0] = 4;
        for (int k = 0; k < 4; k++) begin
            pd[0][k] = 8'h50 + 8'(k); pl[0][k] = (k == 3);
        end
        gap_at[0] = 2; gap_len[0] = 5;
        plen[1] = 1; pd[1][0] = 8'h60; pl[1][0] = 1;
        run_until(2, 40);
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq($sformatf("ni_grant%0d", k), 32'(s_grant), 32'h1);
            check_eq($sformatf("ni_ready1_%0d", k), 32'(s_iready[1]), 32'h0);
        end
        run_until(5, 60);
        check_eq("ni_count", nobs, 5);
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("ni_data%0d", k), 32'(obs_d[k]), 32'(e5d[k]));
            check_eq($sformatf("ni_grant_x%0d", k), 32'(obs_g[k]), 32'(e5g[k]));
        end

        // async reset in the middle of a packet
        restart();
        plen[2] = 2;
        pd[2][0] = 8'h55; pl[2][0] = 0;
        pd[2][1] = 8'h66; pl[2][1] = 1;
        oready = 1'b1;
`ifdef RS232_TX_ARB_TAG_EN
        begin
            int t;
            t = 0;
            while (!s_ovalid && t < 20) begin step(); t++; end
            check_eq("tag_hdr", 32'(s_odata), 32'hA2);
            check_eq("tag_hdr_last", 32'(s_olast), 32'h0);
            check_eq("tag_hdr_ready", 32'(s_iready), 32'h0);
        end
`endif
        begin
            int t;
            t = 0;
            while (!(s_ovalid && (|s_iready)) && t < 20) begin step(); t++; end
            check_eq("ar_seen", 32'(s_ovalid && (|s_iready)), 32'h1);
        end
        check_eq("ar_data", 32'(s_odata), 32'h55);
        resetn = 1'b0;
        #1;
        check_eq("ar_ovalid", 32'(s_ovalid), 32'h0);
        check_eq("ar_odata", 32'(s_odata), 32'h0);
        check_eq("ar_olast", 32'(s_olast), 32'h0);
        check_eq("ar_iready", 32'(s_iready), 32'h0);
        check_eq("ar_grant", 32'(s_grant), 32'h0);
        check_eq("ar_busy", 32'(s_busy), 32'h0);
        model_clear();
        step();
        resetn = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
